// File: rtl/pong_pkg.sv
// Shared types and default geometry/colour constants for the Pong pixel engine.
package pong_pkg;

    typedef logic [9:0] coord_t;

    typedef enum logic [1:0] {
        SERVE     = 2'd0,
        PLAY      = 2'd1,
        MISS_WAIT = 2'd2
    } ball_state_t;

    localparam int DEF_H_RES       = 640;
    localparam int DEF_V_RES       = 480;
    localparam int DEF_WALL_X_L    = 32;
    localparam int DEF_WALL_X_R    = 35;
    localparam int DEF_PADDLE_X_L  = 600;
    localparam int DEF_PADDLE_H    = 72;
    localparam int DEF_PADDLE_V    = 4;
    localparam int DEF_BALL_SIZE   = 8;
    localparam int DEF_BALL_V      = 2;
    localparam int DEF_BALL_X0     = 320;
    localparam int DEF_BALL_Y0     = 236;
    localparam int DEF_MISS_FRAMES = 60;
    localparam int DEF_SCORE_W     = 4;

    localparam logic [11:0] DEF_WALL_RGB   = 12'hFFF;
    localparam logic [11:0] DEF_PADDLE_RGB = 12'h0F0;
    localparam logic [11:0] DEF_BG_RGB     = 12'h000;

    // Coordinates are compared at 11 bits so that sums never wrap.
    function automatic logic [10:0] ext11(input coord_t v);
        return {1'b0, v};
    endfunction

endpackage

// File: rtl/pong_ball_motion.sv
// Ball state machine: serve, per-frame motion with wall/floor/paddle bounces, miss handling.
module pong_ball_motion
    import pong_pkg::*;
#(
    parameter int H_RES       = DEF_H_RES,
    parameter int V_RES       = DEF_V_RES,
    parameter int WALL_X_R    = DEF_WALL_X_R,
    parameter int PADDLE_X_L  = DEF_PADDLE_X_L,
    parameter int PADDLE_H    = DEF_PADDLE_H,
    parameter int BALL_SIZE   = DEF_BALL_SIZE,
    parameter int BALL_V      = DEF_BALL_V,
    parameter int BALL_X0     = DEF_BALL_X0,
    parameter int BALL_Y0     = DEF_BALL_Y0,
    parameter int MISS_FRAMES = DEF_MISS_FRAMES
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   frame_tick,
    input  logic   btn_serve,
    input  coord_t paddle_y,
    output coord_t ball_x,
    output coord_t ball_y,
    output logic   visible,
    output logic   hit,
    output logic   miss
);

    localparam int CNT_W = (MISS_FRAMES > 1) ? $clog2(MISS_FRAMES) : 1;

    ball_state_t      state;
    logic             dx_neg;
    logic             dy_neg;
    logic [CNT_W-1:0] frame_cnt;

    logic [10:0] bx, by, py, right_edge;
    logic        dx_neg_nx, dy_neg_nx, paddle_hit, wall_miss;
    coord_t      x_nx, y_nx;

    assign bx         = ext11(ball_x);
    assign by         = ext11(ball_y);
    assign py         = ext11(paddle_y);
    assign right_edge = bx + 11'(BALL_SIZE - 1);

    always_comb begin
        dy_neg_nx = dy_neg;
        if (by <= 11'(BALL_V))
            dy_neg_nx = 1'b0;
        else if (by + 11'(BALL_SIZE + BALL_V) >= 11'(V_RES))
            dy_neg_nx = 1'b1;

        dx_neg_nx  = dx_neg;
        paddle_hit = 1'b0;
        wall_miss  = 1'b0;
        if (bx <= 11'(WALL_X_R + BALL_V)) begin
            dx_neg_nx = 1'b0;
        end else if (!dx_neg
                     && right_edge >= 11'(PADDLE_X_L - BALL_V)
                     && right_edge <= 11'(PADDLE_X_L - 1)
                     && by + 11'(BALL_SIZE - 1) >= py
                     && by <= py + 11'(PADDLE_H - 1)) begin
            dx_neg_nx  = 1'b1;
            paddle_hit = 1'b1;
        end else if (bx + 11'(BALL_SIZE) >= 11'(H_RES - BALL_V)) begin
            wall_miss = 1'b1;
        end
    end

    assign x_nx = dx_neg_nx ? ball_x - coord_t'(BALL_V) : ball_x + coord_t'(BALL_V);
    assign y_nx = dy_neg_nx ? ball_y - coord_t'(BALL_V) : ball_y + coord_t'(BALL_V);

    // Strobe lines up with the tick edge so the score updates in the same frame.
    assign miss = frame_tick && (state == PLAY) && wall_miss;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= SERVE;
            ball_x    <= coord_t'(BALL_X0);
            ball_y    <= coord_t'(BALL_Y0);
            dx_neg    <= 1'b1;
            dy_neg    <= 1'b0;
            frame_cnt <= '0;
            visible   <= 1'b1;
            hit       <= 1'b0;
        end else begin
            hit <= 1'b0;
            if (frame_tick) begin
                case (state)
                    SERVE: begin
                        if (btn_serve)
                            state <= PLAY;
                    end
                    PLAY: begin
                        if (wall_miss) begin
                            state     <= MISS_WAIT;
                            frame_cnt <= '0;
                            visible   <= 1'b0;
                        end else begin
                            dx_neg <= dx_neg_nx;
                            dy_neg <= dy_neg_nx;
                            ball_x <= x_nx;
                            ball_y <= y_nx;
                            hit    <= paddle_hit;
                        end
                    end
                    MISS_WAIT: begin
                        if (frame_cnt == CNT_W'(MISS_FRAMES - 1)) begin
                            state   <= SERVE;
                            ball_x  <= coord_t'(BALL_X0);
                            ball_y  <= coord_t'(BALL_Y0);
                            dx_neg  <= 1'b1;
                            dy_neg  <= 1'b0;
                            visible <= 1'b1;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                    default: state <= SERVE;
                endcase
            end
        end
    end

endmodule

// File: rtl/pong_pixel_engine.sv
// Pong pixel engine: frame tick, paddle control, miss score and registered pixel colour mux.
module pong_pixel_engine
    import pong_pkg::*;
#(
    parameter int          H_RES       = DEF_H_RES,
    parameter int          V_RES       = DEF_V_RES,
    parameter int          WALL_X_L    = DEF_WALL_X_L,
    parameter int          WALL_X_R    = DEF_WALL_X_R,
    parameter int          PADDLE_X_L  = DEF_PADDLE_X_L,
    parameter int          PADDLE_H    = DEF_PADDLE_H,
    parameter int          PADDLE_V    = DEF_PADDLE_V,
    parameter int          BALL_SIZE   = DEF_BALL_SIZE,
    parameter int          BALL_V      = DEF_BALL_V,
    parameter int          BALL_X0     = DEF_BALL_X0,
    parameter int          BALL_Y0     = DEF_BALL_Y0,
    parameter int          MISS_FRAMES = DEF_MISS_FRAMES,
    parameter int          SCORE_W     = DEF_SCORE_W,
    parameter logic [11:0] WALL_RGB    = DEF_WALL_RGB,
    parameter logic [11:0] PADDLE_RGB  = DEF_PADDLE_RGB,
    parameter logic [11:0] BG_RGB      = DEF_BG_RGB
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               video_on,
    input  logic [9:0]         pixel_x,
    input  logic [9:0]         pixel_y,
    input  logic [11:0]        ball_rgb,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_serve,
    output logic [11:0]        rgb_out,
    output logic [SCORE_W-1:0] miss_count,
    output logic               hit
);

    localparam int PADDLE_Y_MAX = V_RES - PADDLE_H;

    logic   tick_pos, tick_pos_d, frame_tick;
    coord_t paddle_y, ball_x, ball_y;
    logic   visible, miss;

    // First line below the visible area, column 0: one tick per frame at any pixel rate.
    assign tick_pos   = (pixel_y == coord_t'(V_RES)) && (pixel_x == '0);
    assign frame_tick = tick_pos && !tick_pos_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            tick_pos_d <= 1'b0;
        else
            tick_pos_d <= tick_pos;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            paddle_y <= coord_t'(PADDLE_Y_MAX / 2);
        end else if (frame_tick) begin
            if (btn_up && !btn_down)
                paddle_y <= (paddle_y <= coord_t'(PADDLE_V)) ? '0 : paddle_y - coord_t'(PADDLE_V);
            else if (btn_down && !btn_up)
                paddle_y <= (ext11(paddle_y) + 11'(PADDLE_V) >= 11'(PADDLE_Y_MAX))
                            ? coord_t'(PADDLE_Y_MAX) : paddle_y + coord_t'(PADDLE_V);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            miss_count <= '0;
        else if (miss && (miss_count != '1))
            miss_count <= miss_count + 1'b1;
    end

    pong_ball_motion #(
        .H_RES      (H_RES),
        .V_RES      (V_RES),
        .WALL_X_R   (WALL_X_R),
        .PADDLE_X_L (PADDLE_X_L),
        .PADDLE_H   (PADDLE_H),
        .BALL_SIZE  (BALL_SIZE),
        .BALL_V     (BALL_V),
        .BALL_X0    (BALL_X0),
        .BALL_Y0    (BALL_Y0),
        .MISS_FRAMES(MISS_FRAMES)
    ) u_motion (
        .clock     (clock),
        .reset     (reset),
        .frame_tick(frame_tick),
        .btn_serve (btn_serve),
        .paddle_y  (paddle_y),
        .ball_x    (ball_x),
        .ball_y    (ball_y),
        .visible   (visible),
        .hit       (hit),
        .miss      (miss)
    );

    logic [10:0] px, py, pad_y, bx, by;
    logic        in_wall, in_paddle, in_ball;
    logic [11:0] colour;

    assign px    = ext11(pixel_x);
    assign py    = ext11(pixel_y);
    assign pad_y = ext11(paddle_y);
    assign bx    = ext11(ball_x);
    assign by    = ext11(ball_y);

    assign in_wall   = (px >= 11'(WALL_X_L)) && (px <= 11'(WALL_X_R));
    assign in_paddle = (px >= 11'(PADDLE_X_L)) && (px <= 11'(PADDLE_X_L + 3))
                    && (py >= pad_y) && (py <= pad_y + 11'(PADDLE_H - 1));
    assign in_ball   = visible
                    && (px >= bx) && (px <= bx + 11'(BALL_SIZE - 1))
                    && (py >= by) && (py <= by + 11'(BALL_SIZE - 1));

    always_comb begin
        colour = BG_RGB;
        if (in_wall)
            colour = WALL_RGB;
        else if (in_paddle)
            colour = PADDLE_RGB;
        else if (in_ball)
            colour = ball_rgb;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            rgb_out <= '0;
        else
            rgb_out <= video_on ? colour : '0;
    end

endmodule

// File: tb/tb_pong_pixel_engine.sv
// Directed bench for pong_pixel_engine with a frame-level reference model and expectation queue.
module tb_pong_pixel_engine;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        video_on = 1'b0;
    logic [9:0]  pixel_x = '0;
    logic [9:0]  pixel_y = '0;
    logic [11:0] ball_rgb = 12'hA5C;
    logic        btn_up = 1'b0;
    logic        btn_down = 1'b0;
    logic        btn_serve = 1'b0;
    logic [11:0] rgb_out;
    logic [3:0]  miss_count;
    logic        hit;

    pong_pixel_engine dut (
        .clock     (clock),
        .reset     (reset),
        .video_on  (video_on),
        .pixel_x   (pixel_x),
        .pixel_y   (pixel_y),
        .ball_rgb  (ball_rgb),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_serve (btn_serve),
        .rgb_out   (rgb_out),
        .miss_count(miss_count),
        .hit       (hit)
    );

    always #5 clock = ~clock;

    initial begin
        #3000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    logic last_hit = 1'b0;

    localparam int M_SERVE = 0, M_PLAY = 1, M_MISS = 2;
    int mbx, mby, mpad, mstate, mcnt, mmiss;
    bit mdxn, mdyn, mhit;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_val(input string tag, input int exp);
        exp_t e;
        e.tag = tag;
        e.exp = 32'(exp);
        sb.push_back(e);
    endtask

    task automatic check_next(input logic [31:0] obs);
        exp_t e;
        n_assert++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=%0d", obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.exp);
        end
    endtask

    task automatic model_reset();
        mbx = 320; mby = 236; mdxn = 1; mdyn = 0;
        mpad = 204; mstate = M_SERVE; mcnt = 0; mmiss = 0; mhit = 0;
    endtask

    task automatic model_tick(input bit up, input bit dn, input bit srv);
        bit ndx, ndy, lost;
        mhit = 0;
        case (mstate)
            M_SERVE: if (srv) mstate = M_PLAY;
            M_PLAY: begin
                ndy = mdyn;
                if (mby <= 2) ndy = 0;
                else if (mby + 10 >= 480) ndy = 1;
                ndx = mdxn;
                lost = 0;
                if (mbx <= 37) ndx = 0;
                else if (!mdxn && mbx + 7 >= 598 && mbx + 7 <= 599
                         && mby + 7 >= mpad && mby <= mpad + 71) begin
                    ndx = 1; mhit = 1;
                end else if (mbx + 8 >= 638) lost = 1;
                if (lost) begin
                    mstate = M_MISS; mcnt = 0;
                    if (mmiss < 15) mmiss++;
                end else begin
                    mdxn = ndx; mdyn = ndy;
                    mbx = ndx ? mbx - 2 : mbx + 2;
                    mby = ndy ? mby - 2 : mby + 2;
                end
            end
            default: begin
                if (mcnt == 59) begin
                    mstate = M_SERVE; mbx = 320; mby = 236; mdxn = 1; mdyn = 0;
                end else mcnt++;
            end
        endcase
        if (up && !dn) mpad = (mpad - 4 < 0) ? 0 : mpad - 4;
        else if (dn && !up) mpad = (mpad + 4 > 408) ? 408 : mpad + 4;
    endtask

    // One frame: tick at (0,480), then back to line 0.
    task automatic frame(input bit up, input bit dn, input bit srv);
        model_tick(up, dn, srv);
        expect_val("ball_x", mbx);
        expect_val("ball_y", mby);
        expect_val("paddle_y", mpad);
        expect_val("hit_pulse", mhit);
        expect_val("miss_count", mmiss);
        expect_val("hit_low_after", 0);
        btn_up = up; btn_down = dn; btn_serve = srv;
        video_on = 0; pixel_x = 0; pixel_y = 10'd480;
        step();
        last_hit = hit;
        check_next(32'(dut.ball_x));
        check_next(32'(dut.ball_y));
        check_next(32'(dut.paddle_y));
        check_next(32'(hit));
        check_next(32'(miss_count));
        pixel_y = 0;
        step();
        check_next(32'(hit));
        btn_up = 0; btn_down = 0; btn_serve = 0;
    endtask

    task automatic probe(input string tag, input int x, input int y,
                         input logic [11:0] exp, input bit von = 1'b1);
        expect_val(tag, exp);
        video_on = von; pixel_x = x[9:0]; pixel_y = y[9:0];
        step();
        check_next(32'(rgb_out));
        video_on = 0;
    endtask

    initial begin
        int target;
        bit up, dn;
        model_reset();
        repeat (3) step();
        reset = 1;
        step();

        // Reset asserted mid-operation acts without a clock edge.
        repeat (3) frame(1, 0, 0);
        probe("wall_pre_reset", 33, 100, 12'hFFF);
        #2 reset = 0;
        model_reset();
        #1;
        expect_val("rgb_async_reset", 0);
        check_next(32'(rgb_out));
        expect_val("paddle_async_reset", 204);
        check_next(32'(dut.paddle_y));
        expect_val("miss_async_reset", 0);
        check_next(32'(miss_count));
        step();
        reset = 1;
        step();

        probe("video_off", 33, 100, 12'h000, 1'b0);
        probe("wall", 33, 100, 12'hFFF);
        probe("background", 100, 100, 12'h000);
        probe("wall_right_col", 35, 479, 12'hFFF);
        probe("past_wall", 36, 0, 12'h000);
        probe("paddle_top_left", 600, 204, 12'h0F0);
        probe("paddle_bot_right", 603, 275, 12'h0F0);
        probe("paddle_right_out", 604, 204, 12'h000);
        probe("paddle_above", 600, 203, 12'h000);
        probe("paddle_below", 600, 276, 12'h000);
        probe("ball_top_left", 320, 236, 12'hA5C);
        probe("ball_bot_right", 327, 243, 12'hA5C);
        probe("ball_right_out", 328, 243, 12'h000);
        probe("ball_below", 320, 244, 12'h000);

        // Paddle motion and clamping.
        repeat (10) frame(1, 0, 0);
        probe("paddle_at_164", 600, 164, 12'h0F0);
        probe("paddle_above_164", 600, 163, 12'h000);
        repeat (60) frame(1, 0, 0);
        probe("paddle_at_0", 600, 0, 12'h0F0);
        probe("paddle_end_71", 600, 72, 12'h000);
        repeat (3) frame(1, 1, 0);
        probe("paddle_both_hold", 600, 71, 12'h0F0);
        repeat (3) frame(0, 1, 0);
        expect_val("paddle_down_12", 12);
        check_next(32'(dut.paddle_y));

        // Serve, floor bounce, wall bounce.
        frame(0, 0, 1);
        for (int i = 0; i < 400 && mby != 470; i++) frame(0, 0, 0);
        expect_val("ball_y_reaches_470", 470);
        check_next(32'(dut.ball_y));
        frame(0, 0, 0);
        expect_val("ball_y_after_floor", 468);
        check_next(32'(dut.ball_y));
        probe("ball_drawn_468", mbx, 468, 12'hA5C);
        for (int i = 0; i < 400 && mbx != 36; i++) frame(0, 0, 0);
        expect_val("ball_x_reaches_36", 36);
        check_next(32'(dut.ball_x));
        frame(0, 0, 0);
        expect_val("ball_x_after_wall", 38);
        check_next(32'(dut.ball_x));

        // Track the ball with the paddle until it is returned.
        for (int i = 0; i < 1000 && !mhit; i++) begin
            target = mby - 32;
            if (target < 0) target = 0;
            if (target > 408) target = 408;
            up = (mpad > target + 2);
            dn = (mpad < target - 2);
            frame(up, dn, 0);
        end
        expect_val("paddle_hit_seen", 1);
        check_next(32'(last_hit));
        expect_val("ball_x_at_hit", 590);
        check_next(32'(dut.ball_x));
        expect_val("miss_after_hit", 0);
        check_next(32'(miss_count));
        frame(0, 0, 0);
        expect_val("ball_x_leaving", 588);
        check_next(32'(dut.ball_x));

        // Misses with the paddle parked at the top; score saturates.
        for (int m = 0; m < 16; m++) begin
            if (mstate == M_SERVE) frame(1, 0, 1);
            for (int i = 0; i < 3000 && mstate != M_MISS; i++) frame(1, 0, 0);
            expect_val("miss_count_step", (m + 1 > 15) ? 15 : m + 1);
            check_next(32'(miss_count));
            if (m == 0) begin
                probe("ball_hidden_first", mbx, mby, 12'h000);
                repeat (59) frame(1, 0, 0);
                probe("ball_hidden_frame59", mbx, mby, 12'h000);
                frame(1, 0, 0);
                probe("ball_reserved", 320, 236, 12'hA5C);
                probe("ball_reserved_corner", 327, 243, 12'hA5C);
            end else begin
                repeat (60) frame(1, 0, 0);
            end
        end
        expect_val("miss_count_saturated", 15);
        check_next(32'(miss_count));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
